// File: rtl/sr_arb_pkg.sv
// Shared types, op encodings and the round-robin pick helper for sr_flag_arbiter.
package sr_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam logic OP_SET  = 1'b1;
  localparam logic OP_CLR  = 1'b0;
  localparam int   MAX_REQ = 16;

  // One-hot winner: first eligible index at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                                 input logic [3:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] win;
    logic               found;
    int                 idx_i;
    logic [3:0]         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx_i = (int'(ptr) + k) % n;
      idx   = 4'(idx_i);
      if (k < n && !found && elig[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_sr_ff.sv
// Clocked SR flag cell with an asynchronous clear path; S has priority only by
// construction, the arbiter never drives S and R together.
module sr_ff (
  input  logic clk,
  input  logic clr,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic QB
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (S) begin
      q_d = 1'b1;
    end else if (R) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign QB = ~q_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing one SR flag between NUM_REQ requesters, with a
// post-change hold window. Optional conflict counter under SR_ARB_STATS_EN.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op,
  output logic [NUM_REQ-1:0] gnt,
  output logic               Q,
  output logic               QB,
  output logic               busy
`ifdef SR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]   conflict_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic [NUM_REQ-1:0] elig, win;
  logic [MAX_REQ-1:0] win_full;
  logic               win_any, win_op;
  logic [PW-1:0]      win_idx;
  logic               s_strb, r_strb;

  // A requester is blind during its own grant cycle so a held req is not re-won.
  always_comb begin
    elig     = req & ~gnt_q;
    win_full = rr_pick(MAX_REQ'(elig), 4'(ptr_q), NUM_REQ);
    win_any  = |win_full;
    win      = win_full[NUM_REQ-1:0];
    win_op   = |(win & op);
    win_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = '0;
    s_strb  = 1'b0;
    r_strb  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (win_any) begin
          gnt_d  = win;
          s_strb = (win_op == OP_SET);
          r_strb = (win_op == OP_CLR);
          ptr_d  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          if ((win_op != Q) && (HOLD_CYCLES > 0)) begin
            state_d = ARB_HOLD;
            hold_d  = HW'(HOLD_CYCLES);
          end
        end
      end
      ARB_HOLD: begin
        hold_d = hold_q - 1'b1;
        if (hold_q == HW'(1)) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  sr_ff u_flag (
    .clk (clk),
    .clr (rst),
    .S   (s_strb),
    .R   (r_strb),
    .Q   (Q),
    .QB  (QB)
  );

  assign gnt  = gnt_q;
  assign busy = (state_q == ARB_HOLD);

`ifdef SR_ARB_STATS_EN
  logic             conflict;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign conflict = (state_q == ARB_IDLE) && (|(elig & op)) && (|(elig & ~op));

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: dut (HOLD=3) and dut0 (HOLD=0, CNT_W=2).
module tb_sr_flag_arbiter;

  typedef struct {
    logic [3:0] gnt;
    logic       q;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, op, gnt;
  logic       q, qb, busy;
  logic [3:0] req_z, op_z, gnt_z;
  logic       q_z, qb_z, busy_z;
`ifdef SR_ARB_STATS_EN
  logic [7:0] cnt;
  logic [1:0] cnt_z;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .gnt(gnt), .Q(q), .QB(qb), .busy(busy)
`ifdef SR_ARB_STATS_EN
    , .conflict_cnt(cnt)
`endif
  );

  sr_flag_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .req(req_z), .op(op_z), .gnt(gnt_z), .Q(q_z), .QB(qb_z), .busy(busy_z)
`ifdef SR_ARB_STATS_EN
    , .conflict_cnt(cnt_z)
`endif
  );

  // S and R must never be driven together on either instance.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if ((dut.s_strb && dut.r_strb) || (dut0.s_strb && dut0.r_strb)) begin
        n_fail++;
        $display("FAIL sr_exclusive got S=%b R=%b / S0=%b R0=%b exp never both 1",
                 dut.s_strb, dut.r_strb, dut0.s_strb, dut0.r_strb);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    n_tests++; if (q !== 1'b0 || qb !== 1'b1) begin n_fail++; $display("FAIL reset_q got Q=%b QB=%b exp 0/1", q, qb); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (dut.ptr_q !== 2'd0) begin n_fail++; $display("FAIL reset_ptr got %0d exp 0", dut.ptr_q); end
`ifdef SR_ARB_STATS_EN
    n_tests++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    int   got = 0;
    int   bcnt = 0;
    op  = 4'b0001;
    req = 4'b0001;
    sb.push_back('{4'b0001, 1'b1});
    for (int c = 0; c < 5 && got == 0; c++) begin
      tick();
      if (gnt !== 4'b0000) begin
        got = 1;
        req = 4'b0000;
        e = sb.pop_front();
        n_tests++; if (gnt !== e.gnt) begin n_fail++; $display("FAIL single_gnt got %b exp %b", gnt, e.gnt); end
        n_tests++; if (q !== e.q || qb !== ~e.q) begin n_fail++; $display("FAIL single_q got Q=%b QB=%b exp Q=%b", q, qb, e.q); end
        n_tests++; if (c !== 0) begin n_fail++; $display("FAIL single_latency got %0d exp 1", c + 1); end
      end
    end
    if (got == 0) begin n_tests++; n_fail++; $display("FAIL single_timeout got no grant exp 0001"); end
    for (int c = 0; c < 6; c++) begin
      if (busy) bcnt++;
      if (c == 1) begin
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_pulse got %b exp 0000", gnt); end
      end
      tick();
    end
    n_tests++; if (bcnt !== 3) begin n_fail++; $display("FAIL single_busy got %0d exp 3", bcnt); end
    n_tests++; if (dut.ptr_q !== 2'd1) begin n_fail++; $display("FAIL single_ptr got %0d exp 1", dut.ptr_q); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   got = 0;
    int   last = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111;
    op  = 4'b0101;
    sb.push_back('{4'b0001, 1'b1});
    sb.push_back('{4'b0010, 1'b0});
    sb.push_back('{4'b0100, 1'b1});
    sb.push_back('{4'b1000, 1'b0});
    for (int c = 0; c < 40 && got < 4; c++) begin
      tick();
      if (gnt !== 4'b0000) begin
        e = sb.pop_front();
        n_tests++; if (gnt !== e.gnt) begin n_fail++; $display("FAIL rr_gnt got %b exp %b", gnt, e.gnt); end
        n_tests++; if (q !== e.q || qb !== ~e.q) begin n_fail++; $display("FAIL rr_q got Q=%b QB=%b exp Q=%b", q, qb, e.q); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy got %b exp 1", busy); end
        if (got > 0) begin
          n_tests++; if (c - last !== 4) begin n_fail++; $display("FAIL rr_spacing got %0d exp 4", c - last); end
        end
        last = c;
        got++;
        if (got == 4) req = 4'b0000;
      end
    end
    if (got < 4) begin n_tests++; n_fail++; $display("FAIL rr_timeout got %0d grants exp 4", got); end
    sb.delete();
`ifdef SR_ARB_STATS_EN
    n_tests++; if (cnt !== 8'd4) begin n_fail++; $display("FAIL rr_conflict got %0d exp 4", cnt); end
`endif
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   got = 0;
    int   last = 0;
    req = 4'b0001;
    op  = 4'b0001;
    for (int c = 0; c < 5 && got == 0; c++) begin
      tick();
      if (gnt !== 4'b0000) begin got = 1; req = 4'b0000; end
    end
    repeat (4) tick();
    n_tests++; if (q !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_setup got Q=%b busy=%b exp 1/0", q, busy); end
    got = 0;
    req = 4'b1100;
    op  = 4'b1100;
    sb.push_back('{4'b0100, 1'b1});
    sb.push_back('{4'b1000, 1'b1});
    for (int c = 0; c < 8 && got < 2; c++) begin
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy got %b exp 0", busy); end
      if (gnt !== 4'b0000) begin
        e = sb.pop_front();
        n_tests++; if (gnt !== e.gnt) begin n_fail++; $display("FAIL b2b_gnt got %b exp %b", gnt, e.gnt); end
        n_tests++; if (q !== e.q) begin n_fail++; $display("FAIL b2b_q got %b exp %b", q, e.q); end
        if (got > 0) begin
          n_tests++; if (c - last !== 1) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 1", c - last); end
        end
        last = c;
        got++;
        req = req & ~gnt;
      end
    end
    if (got < 2) begin n_tests++; n_fail++; $display("FAIL b2b_timeout got %0d grants exp 2", got); end
    sb.delete();
    req = 4'b0000;
`ifdef SR_ARB_STATS_EN
    n_tests++; if (cnt !== 8'd4) begin n_fail++; $display("FAIL b2b_conflict got %0d exp 4", cnt); end
`endif
  endtask

  task automatic test_reset_mid_hold();
    int got = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0001;
    op  = 4'b0001;
    for (int c = 0; c < 5 && got == 0; c++) begin
      tick();
      if (gnt !== 4'b0000) begin got = 1; req = 4'b0000; end
    end
    if (got == 0) begin n_tests++; n_fail++; $display("FAIL mid_setup got no grant exp 0001"); end
    tick();
    tick();
    n_tests++; if (busy !== 1'b1 || q !== 1'b1) begin n_fail++; $display("FAIL mid_pre got busy=%b Q=%b exp 1/1", busy, q); end
    rst = 1'b1;
    #1;
    n_tests++; if (q !== 1'b0 || qb !== 1'b1) begin n_fail++; $display("FAIL mid_rst_q got Q=%b QB=%b exp 0/1", q, qb); end
    n_tests++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_busy got busy=%b gnt=%b exp 0/0000", busy, gnt); end
    tick();
    rst = 1'b0;
    req = 4'b0100;
    op  = 4'b0100;
    tick();
    n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL post_rst_gnt got %b exp 0100", gnt); end
    n_tests++; if (q !== 1'b1) begin n_fail++; $display("FAIL post_rst_q got %b exp 1", q); end
    rst = 1'b1;
    #1;
    n_tests++; if (gnt !== 4'b0000 || q !== 1'b0) begin n_fail++; $display("FAIL grant_rst got gnt=%b Q=%b exp 0000/0", gnt, q); end
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_zero_hold();
    exp_t e;
    int   got = 0;
    int   last = 0;
    req_z = 4'b0011;
    op_z  = 4'b0001;
    sb.push_back('{4'b0001, 1'b1});
    sb.push_back('{4'b0010, 1'b0});
    for (int c = 0; c < 8 && got < 2; c++) begin
      tick();
      n_tests++; if (busy_z !== 1'b0) begin n_fail++; $display("FAIL zh_busy got %b exp 0", busy_z); end
      if (gnt_z !== 4'b0000) begin
        e = sb.pop_front();
        n_tests++; if (gnt_z !== e.gnt) begin n_fail++; $display("FAIL zh_gnt got %b exp %b", gnt_z, e.gnt); end
        n_tests++; if (q_z !== e.q || qb_z !== ~e.q) begin n_fail++; $display("FAIL zh_q got Q=%b QB=%b exp Q=%b", q_z, qb_z, e.q); end
        if (got > 0) begin
          n_tests++; if (c - last !== 1) begin n_fail++; $display("FAIL zh_spacing got %0d exp 1", c - last); end
        end
        last = c;
        got++;
        req_z = req_z & ~gnt_z;
      end
    end
    if (got < 2) begin n_tests++; n_fail++; $display("FAIL zh_timeout got %0d grants exp 2", got); end
    sb.delete();
    req_z = 4'b0000;
    tick();
  endtask

`ifdef SR_ARB_STATS_EN
  task automatic test_saturate();
    int exp_c;
    rst = 1'b1; tick(); rst = 1'b0;
    req_z = 4'b1111;
    op_z  = 4'b0101;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_c = (k > 3) ? 3 : k;
      n_tests++; if (cnt_z !== 2'(exp_c)) begin n_fail++; $display("FAIL sat_cnt step %0d got %0d exp %0d", k, cnt_z, exp_c); end
    end
    req_z = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    op    = 4'b0000;
    req_z = 4'b0000;
    op_z  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_hold();
    test_zero_hold();
`ifdef SR_ARB_STATS_EN
    test_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
